cnn_layer_seq: RTL and testbench
================================

CNN_LAYER_SEQ -- requirements
Module: cnn_layer_seq

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4: number of layer engines sequenced (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 24'd2000000: watchdog limit per layer, in cycles.
REQ-003 SHALL have clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have start, input, 1: begin a network pass; sampled only in IDLE.
REQ-006 SHALL have abort, input, 1: cancel the pass; sampled in any state.
REQ-007 SHALL have busy, output, 1: high from the LAUNCH state until the pass finishes or is aborted.
REQ-008 SHALL have done, output, 1: one-cycle pulse when the pass completes.
REQ-009 SHALL have err, output, 1: sticky watchdog error flag.
REQ-010 SHALL have cur_layer, output, 3: index of the active layer.
REQ-011 SHALL have layer_start, output, NUM_LAYERS: level start for each engine.
REQ-012 SHALL have layer_end, input, NUM_LAYERS: end flag from each engine.
REQ-013 SHALL have per-layer RAM write and read request buses, input, flattened: eng_addr_w[16*N], eng_data_w[8*N], eng_en[N], eng_wea[N], eng_addr_r[16*N], eng_en_r[N].
REQ-014 SHALL have ram_addr_w/ram_data_w/ram_en/ram_wea/ram_addr_r/ram_en_r, output, 16/8/1/1/16/1: shared RAM port.
REQ-015 SHALL have ram_bank_r and ram_bank_w, output, 1 each: ping-pong bank select for reads and for writes.

Function
REQ-016 SHALL implement FSM states IDLE, LAUNCH, RUN, DRAIN, DONE, ERR.
REQ-017 IDLE: start=1 SHALL go to LAUNCH with cur_layer=0, bank=0, and err cleared.
REQ-018 LAUNCH SHALL last exactly 1 cycle with the watchdog counter cleared, then go to RUN.
REQ-019 In RUN, layer_start[cur_layer] SHALL be 1 and all other bits 0.
REQ-020 In RUN, layer_end[cur_layer]=1 SHALL go to DRAIN, and layer_start SHALL be 0 from DRAIN onward.
REQ-021 DRAIN SHALL last 2 cycles (RAM write flush).
REQ-022 After DRAIN, if cur_layer==NUM_LAYERS-1 the FSM SHALL go to DONE; otherwise it SHALL increment cur_layer, toggle bank, and go to LAUNCH.
REQ-023 DONE SHALL assert done for 1 cycle, then go to IDLE.
REQ-024 ram_bank_r SHALL equal bank and ram_bank_w SHALL equal ~bank, so layer k reads the output of layer k-1.
REQ-025 In LAUNCH, RUN and DRAIN, the shared RAM port SHALL combinationally mirror only engine cur_layer's buses.
REQ-026 In all other states, ram_en, ram_wea and ram_en_r SHALL be 0, and addresses and data SHALL be 0.
REQ-027 layer_end bits of non-active layers SHALL be ignored; a layer_end already high on entry to RUN SHALL be honoured after 1 RUN cycle.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort SHALL force IDLE on the next edge from any state, with layer_start=0, and done SHALL NOT pulse.
REQ-030 abort SHALL win over a simultaneous layer_end, start or timeout.
REQ-031 busy SHALL be 1 in LAUNCH, RUN and DRAIN, and 0 in IDLE, DONE and ERR.

Reset
REQ-032 When rst_n=0 at a posedge, the next state SHALL be IDLE.
REQ-033 On that reset, busy, done, err, cur_layer, layer_start, bank and the watchdog SHALL be 0, and RAM enables SHALL be 0.
REQ-034 Reset mid-pass SHALL drop layer_start in the same cycle the reset takes effect, with no done pulse.

Configuration
REQ-035 With LAYER_TIMEOUT_EN defined, a 24-bit watchdog SHALL count RUN cycles, and on reaching TIMEOUT_CYC the FSM SHALL go to ERR and set err.
REQ-036 ERR SHALL hold layer_start at 0 and leave err high until start, abort or reset; start in ERR SHALL behave as in IDLE.
REQ-037 Without LAYER_TIMEOUT_EN, the watchdog and the ERR state SHALL be absent, err SHALL be tied to 0, and RUN SHALL wait indefinitely.

Verification
REQ-038 start pulse, NUM_LAYERS=4, each engine raises layer_end 10 cycles after its start -> layer_start walks 0001, 0010, 0100, 1000; ram_bank_w = 1, 0, 1, 0; done high exactly 1 cycle.
REQ-039 During RUN of layer 1, engines 0 and 2 drive eng_en=1 with addr 16'h00AA -> ram_en and ram_addr_w follow engine 1 only.
REQ-040 abort asserted in the same cycle as layer_end[2] -> IDLE next cycle, layer_start=0, no done pulse, cur_layer reset to 0 on the next start.
REQ-041 LAYER_TIMEOUT_EN defined, TIMEOUT_CYC=100, layer 0 never ends -> err=1 after 100 RUN cycles, layer_start=0; a new start clears err.
REQ-042 rst_n=0 for 1 cycle in the middle of RUN of layer 2 -> all outputs at reset values after that edge; start accepted on the next cycle.
REQ-043 start held high through a full pass -> the pass runs once; a second pass starts only from IDLE after DONE.

Source files
------------

// File: rtl/cnn_layer_seq.sv
// Sequences NUM_LAYERS engines through a ping-pong RAM, one layer at a time.
// Define LAYER_TIMEOUT_EN to add the per-layer watchdog and the ERR state.
module cnn_layer_seq #(
    parameter int          NUM_LAYERS  = 4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [2:0]               cur_layer,
    output logic [NUM_LAYERS-1:0]    layer_start,
    input  logic [NUM_LAYERS-1:0]    layer_end,
    input  logic [16*NUM_LAYERS-1:0] eng_addr_w,
    input  logic [8*NUM_LAYERS-1:0]  eng_data_w,
    input  logic [NUM_LAYERS-1:0]    eng_en,
    input  logic [NUM_LAYERS-1:0]    eng_wea,
    input  logic [16*NUM_LAYERS-1:0] eng_addr_r,
    input  logic [NUM_LAYERS-1:0]    eng_en_r,
    output logic [15:0]              ram_addr_w,
    output logic [7:0]               ram_data_w,
    output logic                     ram_en,
    output logic                     ram_wea,
    output logic [15:0]              ram_addr_r,
    output logic                     ram_en_r,
    output logic                     ram_bank_r,
    output logic                     ram_bank_w
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
`ifdef LAYER_TIMEOUT_EN
    localparam logic [2:0] S_ERR    = 3'd5;
`endif

    logic [2:0]            state;
    logic                  bank;
    logic                  drain_cnt;
    logic [NUM_LAYERS-1:0] sel;
    logic                  end_hit;
    logic                  can_start;
    logic                  timeout;

    // One-hot decode of the active layer.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            sel[i] = (cur_layer == 3'(i));
        end
    end

    assign end_hit = (state == S_RUN) && |(layer_end & sel);

`ifdef LAYER_TIMEOUT_EN
    logic [23:0] wd;
    logic        err_q;

    assign can_start = (state == S_IDLE) || (state == S_ERR);
    assign timeout   = (wd == TIMEOUT_CYC - 24'd1);
    assign err       = err_q;

    // Watchdog counts RUN cycles of the current layer; err is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else if (abort) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            if (can_start && start) begin
                err_q <= 1'b0;
            end
            if (state == S_LAUNCH) begin
                wd <= '0;
            end else if (state == S_RUN && !end_hit) begin
                wd <= wd + 24'd1;
                if (timeout) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_cfg;

    assign can_start  = (state == S_IDLE);
    assign timeout    = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = ^{TIMEOUT_CYC, timeout};
`endif

    // Main sequencer: abort overrides every other event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_layer <= '0;
            bank      <= 1'b0;
            drain_cnt <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            cur_layer <= '0;
            bank      <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            unique case (1'b1)
                can_start: begin
                    if (start) begin
                        state     <= S_LAUNCH;
                        cur_layer <= '0;
                        bank      <= 1'b0;
                    end
                end
                (state == S_LAUNCH): begin
                    state     <= S_RUN;
                    drain_cnt <= 1'b0;
                end
                (state == S_RUN): begin
                    if (end_hit) begin
                        state <= S_DRAIN;
`ifdef LAYER_TIMEOUT_EN
                    end else if (timeout) begin
                        state <= S_ERR;
`endif
                    end
                end
                (state == S_DRAIN): begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        if (cur_layer == 3'(NUM_LAYERS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_LAUNCH;
                            cur_layer <= cur_layer + 3'd1;
                            bank      <= ~bank;
                        end
                    end
                end
                (state == S_DONE): begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state == S_LAUNCH) || (state == S_RUN) ||
                         (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign layer_start = (state == S_RUN) ? sel : '0;
    assign ram_bank_r  = bank;
    assign ram_bank_w  = ~bank;

    // Shared RAM port mirrors only the active engine while busy.
    always_comb begin
        ram_addr_w = '0;
        ram_data_w = '0;
        ram_en     = 1'b0;
        ram_wea    = 1'b0;
        ram_addr_r = '0;
        ram_en_r   = 1'b0;
        if (busy) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (sel[i]) begin
                    ram_addr_w = eng_addr_w[i*16 +: 16];
                    ram_data_w = eng_data_w[i*8 +: 8];
                    ram_en     = eng_en[i];
                    ram_wea    = eng_wea[i];
                    ram_addr_r = eng_addr_r[i*16 +: 16];
                    ram_en_r   = eng_en_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Bench for cnn_layer_seq: timeline-model passes plus directed corner cases.
// Build with +define+LAYER_TIMEOUT_EN to exercise the watchdog path.
module tb_cnn_layer_seq;

    localparam int N = 4;

    localparam int P_LAUNCH = 0;
    localparam int P_RUN    = 1;
    localparam int P_LAST   = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_DONE   = 4;
    localparam int P_IDLE   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            err;
    logic [2:0]      cur_layer;
    logic [N-1:0]    layer_start;
    logic [N-1:0]    layer_end;
    logic [16*N-1:0] eng_addr_w;
    logic [8*N-1:0]  eng_data_w;
    logic [N-1:0]    eng_en;
    logic [N-1:0]    eng_wea;
    logic [16*N-1:0] eng_addr_r;
    logic [N-1:0]    eng_en_r;
    logic [15:0]     ram_addr_w;
    logic [7:0]      ram_data_w;
    logic            ram_en;
    logic            ram_wea;
    logic [15:0]     ram_addr_r;
    logic            ram_en_r;
    logic            ram_bank_r;
    logic            ram_bank_w;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cnn_layer_seq #(
        .NUM_LAYERS (N),
        .TIMEOUT_CYC(24'd100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_layer  (cur_layer),
        .layer_start(layer_start),
        .layer_end  (layer_end),
        .eng_addr_w (eng_addr_w),
        .eng_data_w (eng_data_w),
        .eng_en     (eng_en),
        .eng_wea    (eng_wea),
        .eng_addr_r (eng_addr_r),
        .eng_en_r   (eng_en_r),
        .ram_addr_w (ram_addr_w),
        .ram_data_w (ram_data_w),
        .ram_en     (ram_en),
        .ram_wea    (ram_wea),
        .ram_addr_r (ram_addr_r),
        .ram_en_r   (ram_en_r),
        .ram_bank_r (ram_bank_r),
        .ram_bank_w (ram_bank_w)
    );

    typedef struct packed {
        logic [N-1:0][7:0] e;
        logic              hold;
        logic [15:0]       exp_busy;
    } vec_t;

    typedef struct {
        int layer;
        int ph;
    } cyc_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_bus();
        for (int i = 0; i < N; i++) begin
            eng_addr_w[i*16 +: 16] = 16'($urandom);
            eng_addr_r[i*16 +: 16] = 16'($urandom);
            eng_data_w[i*8 +: 8]   = 8'($urandom);
        end
        eng_en   = N'($urandom);
        eng_wea  = N'($urandom);
        eng_en_r = N'($urandom);
    endtask

    task automatic chk_ram_idle(input string tag);
        chk({tag, "_ram_en"}, 32'(ram_en), 0);
        chk({tag, "_ram_wea"}, 32'(ram_wea), 0);
        chk({tag, "_ram_en_r"}, 32'(ram_en_r), 0);
        chk({tag, "_ram_addr_w"}, 32'(ram_addr_w), 0);
        chk({tag, "_ram_addr_r"}, 32'(ram_addr_r), 0);
        chk({tag, "_ram_data_w"}, 32'(ram_data_w), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_cur"}, 32'(cur_layer), 0);
        chk({tag, "_ls"}, 32'(layer_start), 0);
        chk({tag, "_bank_r"}, 32'(ram_bank_r), 0);
        chk({tag, "_bank_w"}, 32'(ram_bank_w), 1);
        chk_ram_idle(tag);
    endtask

    // Timeline model: LAUNCH, e[k] RUN cycles, 2 DRAIN per layer, then DONE.
    task automatic run_pass(input logic [N-1:0][7:0] e, input logic hold,
                            output int busy_cnt);
        cyc_t q[$];
        cyc_t c;
        logic [N-1:0] ls_exp;
        logic         busy_exp;
        busy_cnt = 0;
        for (int k = 0; k < N; k++) begin
            q.push_back('{k, P_LAUNCH});
            for (int r = 1; r <= int'(e[k]); r++) begin
                q.push_back('{k, (r == int'(e[k])) ? P_LAST : P_RUN});
            end
            q.push_back('{k, P_DRAIN});
            q.push_back('{k, P_DRAIN});
        end
        q.push_back('{N - 1, P_DONE});
        q.push_back('{N - 1, P_IDLE});
        q.push_back('{N - 1, P_IDLE});
        @(negedge clk);
        start     = 1'b1;
        layer_end = '0;
        foreach (q[i]) begin
            c = q[i];
            @(negedge clk);
            start     = hold && (c.ph != P_IDLE);
            layer_end = N'($urandom);
            if (c.ph == P_RUN) layer_end[c.layer] = 1'b0;
            if (c.ph == P_LAST) layer_end[c.layer] = 1'b1;
            if (c.ph == P_LAUNCH && e[c.layer] == 8'd1) begin
                layer_end[c.layer] = 1'b1;
            end
            rand_bus();
            #1;
            busy_exp = (c.ph <= P_DRAIN);
            ls_exp   = '0;
            if (c.ph == P_RUN || c.ph == P_LAST) ls_exp[c.layer] = 1'b1;
            if (busy) busy_cnt++;
            chk("pass_busy", 32'(busy), 32'(busy_exp));
            chk("pass_done", 32'(done), 32'(c.ph == P_DONE));
            chk("pass_ls", 32'(layer_start), 32'(ls_exp));
            chk("pass_err", 32'(err), 0);
            if (busy_exp) begin
                chk("pass_cur", 32'(cur_layer), 32'(c.layer));
                chk("pass_bank_r", 32'(ram_bank_r), 32'(c.layer % 2));
                chk("pass_bank_w", 32'(ram_bank_w), 32'(1 - c.layer % 2));
                chk("pass_addr_w", 32'(ram_addr_w),
                    32'(eng_addr_w[c.layer*16 +: 16]));
                chk("pass_addr_r", 32'(ram_addr_r),
                    32'(eng_addr_r[c.layer*16 +: 16]));
                chk("pass_data_w", 32'(ram_data_w),
                    32'(eng_data_w[c.layer*8 +: 8]));
                chk("pass_en", 32'(ram_en), 32'(eng_en[c.layer]));
                chk("pass_wea", 32'(ram_wea), 32'(eng_wea[c.layer]));
                chk("pass_en_r", 32'(ram_en_r), 32'(eng_en_r[c.layer]));
            end else begin
                chk_ram_idle("pass");
            end
        end
        start     = 1'b0;
        layer_end = '0;
    endtask

    // Reactive engines end each layer after one RUN cycle until layer k runs.
    task automatic go_to_layer(input int k, output bit ok);
        logic [N-1:0] want;
        want = '0;
        want[k] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (layer_start == want) begin
                ok = 1'b1;
                break;
            end
            layer_end = layer_start;
        end
        layer_end = '0;
        if (!ok) chk("reach_layer", 0, 1);
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    vec_t tbl[4];
    int   bc;
    bit   ok;
    logic [N-1:0][7:0] er;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        tbl[0] = '{e: {8'd10, 8'd10, 8'd10, 8'd10}, hold: 1'b0,
                   exp_busy: 16'd52};
        tbl[1] = '{e: {8'd1, 8'd1, 8'd1, 8'd1}, hold: 1'b0,
                   exp_busy: 16'd16};
        tbl[2] = '{e: {8'd12, 8'd1, 8'd7, 8'd3}, hold: 1'b1,
                   exp_busy: 16'd35};
        tbl[3] = '{e: {8'd4, 8'd9, 8'd5, 8'd2}, hold: 1'b0,
                   exp_busy: 16'd32};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        layer_end = '0;
        rand_bus();
        eng_en   = '1;
        eng_wea  = '1;
        eng_en_r = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_pass(tbl[i].e, tbl[i].hold, bc);
            chk("tbl_busy_cycles", 32'(bc), 32'(tbl[i].exp_busy));
        end

        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < N; k++) er[k] = 8'($urandom_range(1, 12));
            run_pass(er, 1'($urandom), bc);
        end

        // abort beats a simultaneous start in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("abort_vs_start_busy", 32'(busy), 0);

        // abort together with layer_end of layer 2
        kick();
        go_to_layer(2, ok);
        layer_end = 4'b0100;
        abort     = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        layer_end = '0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ls", 32'(layer_start), 0);
        chk("abort_done", 32'(done), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", 32'(done), 0);
        end
        kick();
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart_cur", 32'(cur_layer), 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_ls_launch", 32'(layer_start), 0);
        @(negedge clk);
        #1;
        chk("restart_ls_run", 32'(layer_start), 32'b0001);
        do_abort();

        // non-active engines must not reach the shared port
        kick();
        go_to_layer(1, ok);
        eng_en = 4'b0101;
        eng_addr_w = {16'h0000, 16'h00AA, 16'h1234, 16'h00AA};
        #1;
        chk("mux_en_off", 32'(ram_en), 0);
        chk("mux_addr_w", 32'(ram_addr_w), 32'h1234);
        chk("mux_bank_w", 32'(ram_bank_w), 0);
        eng_en = 4'b0111;
        #1;
        chk("mux_en_on", 32'(ram_en), 1);
        do_abort();

        // reset in the middle of layer 2
        kick();
        go_to_layer(2, ok);
        rst_n  = 1'b0;
        eng_en = '1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_state("midrst");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("midrst_restart", 32'(busy), 1);
        chk("midrst_restart_cur", 32'(cur_layer), 0);
        do_abort();

`ifdef LAYER_TIMEOUT_EN
        kick();
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            #1;
            if (err) begin
                bc = c;
                break;
            end
        end
        chk("wd_cycles", 32'(bc), 101);
        chk("wd_ls", 32'(layer_start), 0);
        chk("wd_busy", 32'(busy), 0);
        @(negedge clk);
        #1;
        chk("wd_sticky", 32'(err), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("wd_clear", 32'(err), 0);
        chk("wd_restart", 32'(busy), 1);
        do_abort();
`else
        kick();
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        chk("nowd_err", 32'(err), 0);
        chk("nowd_ls", 32'(layer_start), 32'b0001);
        do_abort();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
